// File: rtl/priority_mux_out_fifo_if.sv
// priority_mux_out_fifo_if: upstream/downstream handshake, flush and status bundle of the output FIFO
interface priority_mux_out_fifo_if #(
    parameter int N_PRIORITY_WIDTH = 2,
    parameter int N_SIGNAL_WIDTH = 8,
    parameter int N_SIGNALS = 4,
    parameter int DEPTH = 4
);
    localparam int SEL_W = (N_SIGNALS > 1) ? $clog2(N_SIGNALS) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    logic flush;
    logic in_valid;
    logic in_ready;
    logic [N_SIGNAL_WIDTH-1:0] in_data;
    logic [SEL_W-1:0] in_sel;
    logic [N_PRIORITY_WIDTH-1:0] in_priority;
    logic out_valid;
    logic out_ready;
    logic [N_SIGNAL_WIDTH-1:0] out_data;
    logic [SEL_W-1:0] out_sel;
    logic [N_PRIORITY_WIDTH-1:0] out_priority;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] hwm;
    modport master (
        output flush, in_valid, in_data, in_sel, in_priority, out_ready,
        input in_ready, out_valid, out_data, out_sel, out_priority, count, hwm
    );
    modport slave (
        input flush, in_valid, in_data, in_sel, in_priority, out_ready,
        output in_ready, out_valid, out_data, out_sel, out_priority, count, hwm
    );
endinterface

// File: rtl/priority_mux_out_fifo.sv
// priority_mux_out_fifo: first-word-fall-through buffer of {priority, sel, data} with occupancy and high-water mark
module priority_mux_out_fifo #(
    parameter int N_PRIORITY_WIDTH = 2,
    parameter int N_SIGNAL_WIDTH = 8,
    parameter int N_SIGNALS = 4,
    parameter int DEPTH = 4
) (
    input logic clk,
    input logic rst,
    priority_mux_out_fifo_if.slave bus
);
    localparam int SEL_W = (N_SIGNALS > 1) ? $clog2(N_SIGNALS) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    typedef struct packed {
        logic [N_PRIORITY_WIDTH-1:0] pri;
        logic [SEL_W-1:0] sel;
        logic [N_SIGNAL_WIDTH-1:0] data;
    } entry_t;
    entry_t mem [DEPTH];
    entry_t head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hwm_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] hwm_nxt;
    logic full;
    logic empty;
    logic push;
    logic pop;
    assign full = cnt == CNT_W'(DEPTH);
    assign empty = cnt == '0;
    assign push = bus.in_valid & ~full;
    assign pop = ~empty & bus.out_ready;
    // next occupancy and high-water mark; flush discards any same-cycle push or pop
    always_comb begin
        cnt_nxt = cnt;
        if (bus.flush)
            cnt_nxt = '0;
        else if (push && !pop)
            cnt_nxt = cnt + CNT_W'(1);
        else if (pop && !push)
            cnt_nxt = cnt - CNT_W'(1);
        hwm_nxt = bus.flush ? '0 : ((cnt_nxt > hwm_q) ? cnt_nxt : hwm_q);
    end
    // pointer, occupancy and high-water-mark registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt <= '0;
            hwm_q <= '0;
        end else begin
            cnt <= cnt_nxt;
            hwm_q <= hwm_nxt;
            if (bus.flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end
    // storage is written only by an accepted push that is not cancelled by reset or flush
    always_ff @(posedge clk) begin
        if (rst && !bus.flush && push)
            mem[wr_ptr] <= '{pri: bus.in_priority, sel: bus.in_sel, data: bus.in_data};
    end
    // head entry falls through from the read pointer; forced to zero while empty or in reset
    always_comb begin
        head = (rst && !empty) ? mem[rd_ptr] : '0;
    end
    assign bus.in_ready = ~full;
    assign bus.out_valid = rst & ~empty;
    assign bus.out_data = head.data;
    assign bus.out_sel = head.sel;
    assign bus.out_priority = head.pri;
    assign bus.count = cnt;
    assign bus.hwm = hwm_q;
endmodule

// File: tb/tb_priority_mux_out_fifo.sv
// tb_priority_mux_out_fifo: directed vector table, streaming sequence and randomized run against a queue model
module tb_priority_mux_out_fifo;
    localparam int DEPTH = 4;
    typedef struct packed {
        logic [1:0] pri;
        logic [1:0] sel;
        logic [7:0] data;
    } ent_t;
    typedef struct {
        logic r;
        logic f;
        logic iv;
        ent_t e;
        logic ordy;
        logic ov;
        logic ir;
        int c;
        int h;
        ent_t head;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    ent_t q[$];
    int mhwm = 0;
    int passed = 0;
    int total = 0;
    bit init = 1'b0;
    vec_t vecs[$];
    priority_mux_out_fifo_if bus ();
    priority_mux_out_fifo dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    function automatic ent_t mk(int p, int s, int d);
        ent_t e;
        e.pri = 2'(p);
        e.sel = 2'(s);
        e.data = 8'(d);
        return e;
    endfunction
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp)
            passed++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask
    task automatic check_model();
        ent_t h;
        h = (q.size() != 0) ? q[0] : ent_t'(0);
        chk("out_valid", int'(bus.out_valid), int'(q.size() != 0));
        chk("in_ready", int'(bus.in_ready), int'(q.size() != DEPTH));
        chk("count", int'(bus.count), q.size());
        chk("hwm", int'(bus.hwm), mhwm);
        chk("out_data", int'(bus.out_data), int'(h.data));
        chk("out_sel", int'(bus.out_sel), int'(h.sel));
        chk("out_priority", int'(bus.out_priority), int'(h.pri));
    endtask
    task automatic cycle(input logic r, input logic f, input logic iv, input ent_t e, input logic ordy);
        bit push;
        bit pop;
        rst = r;
        bus.flush = f;
        bus.in_valid = iv;
        bus.in_data = e.data;
        bus.in_sel = e.sel;
        bus.in_priority = e.pri;
        bus.out_ready = ordy;
        #1;
        if (init)
            chk("in_ready_pre_edge", int'(bus.in_ready), int'(q.size() != DEPTH));
        push = iv && (q.size() < DEPTH);
        pop = (q.size() > 0) && ordy;
        @(posedge clk);
        #1;
        if (!r || f) begin
            q.delete();
            mhwm = 0;
        end else begin
            if (pop)
                void'(q.pop_front());
            if (push)
                q.push_back(e);
            if (q.size() > mhwm)
                mhwm = q.size();
        end
        if (!r)
            init = 1'b1;
        check_model();
    endtask
    task automatic add(input logic r, input logic f, input logic iv, input ent_t e, input logic ordy,
                       input logic ov, input logic ir, input int c, input int h, input ent_t head);
        vec_t v;
        v.r = r; v.f = f; v.iv = iv; v.e = e; v.ordy = ordy;
        v.ov = ov; v.ir = ir; v.c = c; v.h = h; v.head = head;
        vecs.push_back(v);
    endtask
    initial begin
        ent_t z;
        z = mk(0, 0, 0);
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_sel = '0;
        bus.in_priority = '0;
        bus.out_ready = 1'b0;
        add(0, 0, 0, z, 0, 0, 1, 0, 0, z);
        add(0, 0, 0, z, 0, 0, 1, 0, 0, z);
        add(1, 0, 0, z, 0, 0, 1, 0, 0, z);
        add(1, 0, 1, mk(2, 1, 'hA5), 0, 1, 1, 1, 1, mk(2, 1, 'hA5));
        for (int i = 0; i < 3; i++)
            add(1, 0, 0, z, 0, 1, 1, 1, 1, mk(2, 1, 'hA5));
        add(1, 0, 0, z, 1, 0, 1, 0, 1, z);
        add(1, 0, 1, mk(3, 0, 'h10), 0, 1, 1, 1, 1, mk(3, 0, 'h10));
        add(1, 0, 1, mk(2, 1, 'h11), 0, 1, 1, 2, 2, mk(3, 0, 'h10));
        add(1, 0, 1, mk(1, 2, 'h12), 0, 1, 1, 3, 3, mk(3, 0, 'h10));
        add(1, 0, 1, mk(0, 3, 'h13), 0, 1, 0, 4, 4, mk(3, 0, 'h10));
        add(1, 0, 1, mk(0, 0, 'h14), 0, 1, 0, 4, 4, mk(3, 0, 'h10));
        add(1, 0, 1, mk(0, 0, 'h14), 1, 1, 1, 3, 4, mk(2, 1, 'h11));
        add(1, 0, 1, mk(0, 0, 'h14), 0, 1, 0, 4, 4, mk(2, 1, 'h11));
        add(1, 0, 0, z, 1, 1, 1, 3, 4, mk(1, 2, 'h12));
        add(1, 0, 0, z, 1, 1, 1, 2, 4, mk(0, 3, 'h13));
        add(1, 0, 0, z, 1, 1, 1, 1, 4, mk(0, 0, 'h14));
        add(1, 0, 0, z, 1, 0, 1, 0, 4, z);
        add(1, 1, 0, z, 0, 0, 1, 0, 0, z);
        add(1, 0, 1, mk(1, 0, 'h20), 0, 1, 1, 1, 1, mk(1, 0, 'h20));
        add(1, 0, 1, mk(1, 1, 'h21), 0, 1, 1, 2, 2, mk(1, 0, 'h20));
        add(1, 0, 1, mk(1, 2, 'h22), 0, 1, 1, 3, 3, mk(1, 0, 'h20));
        add(1, 1, 1, mk(3, 3, 'h23), 1, 0, 1, 0, 0, z);
        add(1, 0, 0, z, 1, 0, 1, 0, 0, z);
        add(1, 0, 1, mk(2, 0, 'h30), 0, 1, 1, 1, 1, mk(2, 0, 'h30));
        add(1, 0, 1, mk(2, 1, 'h31), 0, 1, 1, 2, 2, mk(2, 0, 'h30));
        add(1, 0, 1, mk(2, 2, 'h32), 0, 1, 1, 3, 3, mk(2, 0, 'h30));
        add(0, 0, 1, mk(3, 3, 'h33), 1, 0, 1, 0, 0, z);
        add(1, 0, 0, z, 1, 0, 1, 0, 0, z);
        foreach (vecs[i]) begin
            cycle(vecs[i].r, vecs[i].f, vecs[i].iv, vecs[i].e, vecs[i].ordy);
            chk($sformatf("vec%0d_out_valid", i), int'(bus.out_valid), int'(vecs[i].ov));
            chk($sformatf("vec%0d_in_ready", i), int'(bus.in_ready), int'(vecs[i].ir));
            chk($sformatf("vec%0d_count", i), int'(bus.count), vecs[i].c);
            chk($sformatf("vec%0d_hwm", i), int'(bus.hwm), vecs[i].h);
            chk($sformatf("vec%0d_head", i), int'({bus.out_priority, bus.out_sel, bus.out_data}), int'(vecs[i].head));
        end
        for (int k = 0; k < 12; k++) begin
            cycle(1, 0, 1, mk(k % 4, (k + 1) % 4, k), 1);
            chk($sformatf("stream%0d_data", k), int'(bus.out_data), k);
            chk($sformatf("stream%0d_count", k), int'(bus.count), 1);
        end
        cycle(1, 0, 0, z, 1);
        chk("stream_drained", int'(bus.count), 0);
        for (int i = 0; i < 600; i++) begin
            logic r;
            logic f;
            logic iv;
            logic ordy;
            r = ($urandom_range(0, 63) != 0);
            f = ($urandom_range(0, 31) == 0);
            iv = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 99) < ((i % 200) < 100 ? 30 : 75));
            cycle(r, f, iv, mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 255)), ordy);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
